// File: rtl/busfab_pkg.sv
// Shared types and constants for the two-master bus fabric.
package busfab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0;

  function automatic logic [3:0] wait_slice(input logic [31:0] waits, input int unsigned k);
    return waits[4*k +: 4];
  endfunction

endpackage

// File: rtl/busfab_arb.sv
// Fixed-priority two-way arbiter: master 0 wins, master 1 gated by its run enable.
module busfab_arb (
  input  logic clk,
  input  logic reset,
  input  logic idle_i,
  input  logic m0_valid_i,
  input  logic m1_valid_i,
  input  logic m1_en_i,
  output logic gnt_stb_o,
  output logic gnt_id_d_o,
  output logic gnt_id_o
);

  logic gnt_id_q;

  // A grant is only issued from IDLE, so the latched id stays locked until the fabric returns there.
  assign gnt_stb_o  = idle_i & (m0_valid_i | (m1_valid_i & m1_en_i));
  assign gnt_id_d_o = ~m0_valid_i;
  assign gnt_id_o   = gnt_id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_id_q <= 1'b0;
    end else if (gnt_stb_o) begin
      gnt_id_q <= gnt_id_d_o;
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Two-master, N-slave bus interconnect with region decode, wait states and stall.
// Optional stall timeout is enabled by defining BUSFAB_TIMEOUT_EN.
module bus_fabric
  import busfab_pkg::*;
#(
  parameter int unsigned N_SLAVES    = 4,
  parameter int unsigned SEL_LO      = 16,
  parameter int unsigned SEL_W       = 2,
  parameter logic [31:0] WAIT_CYCLES = 32'h0000,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m0_valid,
  input  logic [31:0]                m0_addr,
  input  logic [31:0]                m0_wdata,
  input  logic [3:0]                 m0_wstrb,
  output logic                       m0_ready,
  output logic [31:0]                m0_rdata,
  output logic                       m0_err,
  input  logic                       m1_en,
  input  logic                       m1_valid,
  input  logic [31:0]                m1_addr,
  input  logic [31:0]                m1_wdata,
  input  logic [3:0]                 m1_wstrb,
  output logic                       m1_ready,
  output logic [31:0]                m1_rdata,
  output logic                       m1_err,
  output logic [N_SLAVES-1:0]        s_sel,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_stall
);

  state_e              state_q;
  logic [SEL_W-1:0]    reg_q;
  logic [3:0]          cnt_q;
  logic [N_SLAVES-1:0] s_sel_q;
  logic [31:0]         s_addr_q, s_wdata_q;
  logic [STRB_W-1:0]   s_wstrb_q;
  logic                m0_ready_q, m1_ready_q, m0_err_q, m1_err_q;
  logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;

  logic                gnt_stb, gnt_id_d, gnt_id_q;
  logic [31:0]         gnt_addr, gnt_wdata;
  logic [STRB_W-1:0]   gnt_wstrb;
  logic [SEL_W-1:0]    r_d;
  logic                mapped;
  logic [N_SLAVES-1:0] sel_d;
  logic [DATA_W-1:0]   rd_sel;
  logic                stall_cur, timeout_hit, resp_go, resp_id, resp_err;
  logic [DATA_W-1:0]   resp_data;

  busfab_arb u_arb (
    .clk        (clk),
    .reset      (reset),
    .idle_i     (state_q == ST_IDLE),
    .m0_valid_i (m0_valid),
    .m1_valid_i (m1_valid),
    .m1_en_i    (m1_en),
    .gnt_stb_o  (gnt_stb),
    .gnt_id_d_o (gnt_id_d),
    .gnt_id_o   (gnt_id_q)
  );

  assign gnt_addr  = gnt_id_d ? m1_addr  : m0_addr;
  assign gnt_wdata = gnt_id_d ? m1_wdata : m0_wdata;
  assign gnt_wstrb = gnt_id_d ? m1_wstrb : m0_wstrb;
  assign r_d       = gnt_addr[SEL_LO +: SEL_W];
  assign mapped    = 32'(r_d) < N_SLAVES;

  always_comb begin
    sel_d = '0;
    for (int k = 0; k < int'(N_SLAVES); k++) begin
      sel_d[k] = (32'(r_d) == 32'(k));
    end
  end

  assign rd_sel    = s_rdata[32'(reg_q)*DATA_W +: DATA_W];
  assign stall_cur = s_stall[reg_q];

`ifdef BUSFAB_TIMEOUT_EN
  logic [15:0] stall_q;
  assign timeout_hit = stall_cur && (32'(stall_q) >= TIMEOUT - 1);
`else
  assign timeout_hit = 1'b0;
`endif

  // The response is loaded in the cycle before RESP so ready, rdata and err are registered outputs.
  assign resp_go = ((state_q == ST_IDLE) && gnt_stb && !mapped) ||
                   ((state_q == ST_ACCESS) && (cnt_q == 4'd0) && (!stall_cur || timeout_hit));
  assign resp_id = (state_q == ST_IDLE) ? gnt_id_d : gnt_id_q;

  always_comb begin
    resp_err  = 1'b1;
    resp_data = ERR_RDATA;
    if ((state_q == ST_ACCESS) && !timeout_hit) begin
      resp_err  = 1'b0;
      resp_data = (|s_wstrb_q) ? '0 : rd_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      reg_q      <= '0;
      cnt_q      <= '0;
      s_sel_q    <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
`ifdef BUSFAB_TIMEOUT_EN
      stall_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_stb) begin
            s_addr_q  <= gnt_addr;
            s_wdata_q <= gnt_wdata;
            s_wstrb_q <= gnt_wstrb;
            reg_q     <= r_d;
            if (mapped) begin
              state_q <= ST_ACCESS;
              cnt_q   <= wait_slice(WAIT_CYCLES, 32'(r_d));
              s_sel_q <= sel_d;
            end else begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (resp_go) begin
            state_q <= ST_RESP;
            s_sel_q <= '0;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

`ifdef BUSFAB_TIMEOUT_EN
      if ((state_q == ST_ACCESS) && (cnt_q == 4'd0) && stall_cur && !timeout_hit) begin
        stall_q <= stall_q + 16'd1;
      end else if ((state_q != ST_ACCESS) || resp_go) begin
        stall_q <= '0;
      end
`endif

      if (resp_go) begin
        m0_ready_q <= ~resp_id;
        m1_ready_q <= resp_id;
        m0_err_q   <= ~resp_id & resp_err;
        m1_err_q   <= resp_id & resp_err;
        m0_rdata_q <= resp_id ? '0 : resp_data;
        m1_rdata_q <= resp_id ? resp_data : '0;
      end else if (state_q == ST_RESP) begin
        m0_ready_q <= 1'b0;
        m1_ready_q <= 1'b0;
        m0_err_q   <= 1'b0;
        m1_err_q   <= 1'b0;
        m0_rdata_q <= '0;
        m1_rdata_q <= '0;
      end
    end
  end

  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign s_sel    = s_sel_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: a vector table plus hand-written multi-cycle sequences.
module tb_bus_fabric;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_valid, m1_valid, m1_en;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [127:0] s_rdata4;
  logic [3:0]   s_stall4;

  logic        m0_ready_a, m1_ready_a, m0_err_a, m1_err_a;
  logic [31:0] m0_rdata_a, m1_rdata_a, s_addr_a, s_wdata_a;
  logic [3:0]  s_sel_a, s_wstrb_a;

  logic        m0_ready_b, m1_ready_b, m0_err_b, m1_err_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, s_addr_b, s_wdata_b;
  logic [2:0]  s_sel_b;
  logic [3:0]  s_wstrb_b;

  assign s_rdata4 = {32'h5555_6666, 32'h3333_4444, 32'h1111_2222, 32'hCAFE_F00D};

  bus_fabric #(.N_SLAVES(4), .SEL_LO(16), .SEL_W(2), .WAIT_CYCLES(32'h0000_0300), .TIMEOUT(8)) u_dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready_a), .m0_rdata(m0_rdata_a), .m0_err(m0_err_a),
    .m1_en(m1_en), .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready_a), .m1_rdata(m1_rdata_a), .m1_err(m1_err_a),
    .s_sel(s_sel_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wstrb(s_wstrb_a),
    .s_rdata(s_rdata4), .s_stall(s_stall4)
  );

  bus_fabric #(.N_SLAVES(3), .SEL_LO(16), .SEL_W(2), .WAIT_CYCLES(32'h0000_0000), .TIMEOUT(8)) u_dut3 (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready_b), .m0_rdata(m0_rdata_b), .m0_err(m0_err_b),
    .m1_en(m1_en), .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready_b), .m1_rdata(m1_rdata_b), .m1_err(m1_err_b),
    .s_sel(s_sel_b), .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wstrb(s_wstrb_b),
    .s_rdata(s_rdata4[95:0]), .s_stall(s_stall4[2:0])
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  int          lat;
  logic [31:0] got_rdata, got_saddr;
  logic        got_err, other_rdy;
  logic [3:0]  got_sel;

  task automatic reset_dut();
    reset    = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    m1_en    = 1'b1;
    s_stall4 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic issue(input logic mst, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    if (mst) begin
      m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end else begin
      m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end
  endtask

  // Runs until the given master sees ready on the 4-slave fabric, then drops its valid.
  task automatic wait_ready(input logic mst, input int limit);
    lat = 0; other_rdy = 1'b0; got_rdata = '0; got_err = 1'b0; got_sel = '0; got_saddr = '0;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        got_sel   = s_sel_a;
        got_saddr = s_addr_a;
      end
      if (mst ? m0_ready_a : m1_ready_a) other_rdy = 1'b1;
      if (mst ? m1_ready_a : m0_ready_a) begin
        lat       = n;
        got_rdata = mst ? m1_rdata_a : m0_rdata_a;
        got_err   = mst ? m1_err_a : m0_err_a;
        break;
      end
    end
    if (mst) m1_valid = 1'b0;
    else     m0_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, selcnt, n1;
    logic stable, seen;

    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 2, 4'b0001, 32'hCAFE_F00D, 1'b0};
    vecs[1] = '{1'b1, 32'h0001_0004, 32'h0, 4'h0, 2, 4'b0010, 32'h1111_2222, 1'b0};
    vecs[2] = '{1'b0, 32'h0002_0000, 32'h0, 4'h0, 5, 4'b0100, 32'h3333_4444, 1'b0};
    vecs[3] = '{1'b1, 32'h0003_0008, 32'h0, 4'h0, 2, 4'b1000, 32'h5555_6666, 1'b0};
    vecs[4] = '{1'b0, 32'h0002_0010, 32'h1234_5678, 4'hF, 5, 4'b0100, 32'h0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_00A5, 4'h1, 2, 4'b0001, 32'h0, 1'b0};
    vecs[6] = '{1'b1, 32'h0004_0000, 32'h0, 4'h0, 2, 4'b0001, 32'hCAFE_F00D, 1'b0};

    for (int i = 0; i < 7; i++) begin
      reset_dut();
      issue(vecs[i].mst, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      wait_ready(vecs[i].mst, 20);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].rdata);
      check($sformatf("vec%0d_err", i), {31'b0, got_err}, {31'b0, vecs[i].err});
      check($sformatf("vec%0d_sel", i), {28'b0, got_sel}, {28'b0, vecs[i].sel});
      check($sformatf("vec%0d_saddr", i), got_saddr, vecs[i].addr);
      check($sformatf("vec%0d_other_ready", i), {31'b0, other_rdy}, 32'h0);
    end

    // Simultaneous requests: m0 first, m1 granted in the IDLE cycle after RESP.
    reset_dut();
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    issue(1'b1, 32'h0002_0000, 32'h0, 4'h0);
    wait_ready(1'b0, 20);
    check("prio_m0_latency", lat, 2);
    check("prio_m0_rdata", got_rdata, 32'hCAFE_F00D);
    check("prio_m1_not_ready", {31'b0, other_rdy}, 32'h0);
    selcnt = 0; n1 = 0; got_rdata = '0;
    for (int n = 3; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_sel_a == 4'b0100) selcnt++;
      if (m1_ready_a) begin
        n1 = n;
        got_rdata = m1_rdata_a;
        break;
      end
    end
    m1_valid = 1'b0;
    check("prio_m1_latency", n1, 8);
    check("prio_m1_access_cycles", selcnt, 4);
    check("prio_m1_rdata", got_rdata, 32'h3333_4444);

    // Stalled write: five held cycles after the access cycle.
    reset_dut();
    s_stall4 = 4'b0010;
    issue(1'b1, 32'h0001_0004, 32'h0000_00A5, 4'b0001);
    acc = 0; stable = 1'b1; lat = 0; got_rdata = 32'hFFFF_FFFF; got_err = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_sel_a[1]) begin
        acc++;
        if (s_wdata_a !== 32'h0000_00A5 || s_wstrb_a !== 4'b0001 || s_addr_a !== 32'h0001_0004)
          stable = 1'b0;
      end
      if (n == 6) s_stall4 = '0;
      if (m1_ready_a) begin
        lat = n; got_rdata = m1_rdata_a; got_err = m1_err_a;
        break;
      end
    end
    m1_valid = 1'b0;
    check("stall_latency", lat, 7);
    check("stall_access_cycles", acc, 6);
    check("stall_wdata_stable", {31'b0, stable}, 32'h1);
    check("stall_write_rdata", got_rdata, 32'h0);
    check("stall_err", {31'b0, got_err}, 32'h0);

    // Unmapped region on the 3-slave fabric.
    reset_dut();
    issue(1'b1, 32'h0003_0000, 32'h0, 4'h0);
    seen = 1'b0; lat = 0; got_rdata = 32'hFFFF_FFFF; got_err = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (|s_sel_b) seen = 1'b1;
      if (m1_ready_b) begin
        lat = n; got_rdata = m1_rdata_b; got_err = m1_err_b;
        break;
      end
    end
    m1_valid = 1'b0;
    check("unmapped_latency", lat, 1);
    check("unmapped_err", {31'b0, got_err}, 32'h1);
    check("unmapped_rdata", got_rdata, 32'h0);
    check("unmapped_no_sel", {31'b0, seen}, 32'h0);

    // m1_en low blocks the grant; dropping it mid-access does not abort.
    reset_dut();
    m1_en = 1'b0;
    issue(1'b1, 32'h0002_0000, 32'h0, 4'h0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if ((|s_sel_a) || m1_ready_a) seen = 1'b1;
    end
    check("en_low_no_grant", {31'b0, seen}, 32'h0);
    m1_en = 1'b1;
    lat = 0; got_rdata = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 2) m1_en = 1'b0;
      if (m1_ready_a) begin
        lat = n; got_rdata = m1_rdata_a;
        break;
      end
    end
    m1_valid = 1'b0;
    check("en_drop_latency", lat, 5);
    check("en_drop_rdata", got_rdata, 32'h3333_4444);

    // Reset during ACCESS drops the transaction.
    reset_dut();
    issue(1'b0, 32'h0002_0000, 32'h0, 4'h0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_pre_sel", {28'b0, s_sel_a}, 32'h0000_0004);
    reset = 1'b1;
    m0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ctrl_zero", {26'b0, m0_ready_a, m1_ready_a, m0_err_a, m1_err_a, 2'b0}, 32'h0);
    check("rst_sel_zero", {28'b0, s_sel_a}, 32'h0);
    check("rst_saddr_zero", s_addr_a, 32'h0);
    check("rst_rdata_zero", m0_rdata_a | m1_rdata_a | s_wdata_a | {28'b0, s_wstrb_a}, 32'h0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (m0_ready_a || m1_ready_a || (|s_sel_a)) seen = 1'b1;
    end
    check("rst_no_late_ready", {31'b0, seen}, 32'h0);

`ifdef BUSFAB_TIMEOUT_EN
    // Permanent stall ends in an error response after TIMEOUT stalled cycles.
    reset_dut();
    s_stall4 = 4'b0001;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    wait_ready(1'b0, 30);
    check("timeout_latency", lat, 9);
    check("timeout_err", {31'b0, got_err}, 32'h1);
    check("timeout_rdata", got_rdata, 32'h0);
    s_stall4 = '0;
    @(posedge clk);
    @(negedge clk);
    check("timeout_idle", {27'b0, m0_ready_a, s_sel_a}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
